// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Package  : clk_pkg
// Brief    : Shared scaling helper, thresholds and period type for clock blocks.
// Revision : 1.0 - initial release
// ============================================================================
package clk_pkg;

  localparam int CLK_W         = 16;
  localparam int CLK_FP_OFFSET = 2;
  localparam int CLK_PERIOD_W  = 16;

  typedef logic [CLK_PERIOD_W-1:0] period_t;

  function automatic int FROM_MV(input int mv, input int fp = CLK_FP_OFFSET);
    return mv * (1 << fp);
  endfunction

  localparam logic signed [CLK_W-1:0] SCHMITT_HI = CLK_W'(FROM_MV(2000));
  localparam logic signed [CLK_W-1:0] SCHMITT_LO = CLK_W'(FROM_MV(500));
  localparam logic signed [CLK_W-1:0] OUT_HI     = CLK_W'(FROM_MV(5000));
  localparam logic signed [CLK_W-1:0] OUT_LO     = CLK_W'(FROM_MV(0));

endpackage
`default_nettype wire

// File: rtl/clkmul_if.sv
`default_nettype none
// ============================================================================
// Interface : clkmul_if
// Brief     : Sample-rate strobe plus four sample inputs and four sample outputs.
// Revision  : 1.0 - initial release
// ============================================================================
interface clkmul_if #(
  parameter int W = 16
);
  logic                sample_clk;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;

  modport master (
    output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
    input  sample_out0, sample_out1, sample_out2, sample_out3
  );

  modport slave (
    input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
    output sample_out0, sample_out1, sample_out2, sample_out3
  );
endinterface
`default_nettype wire

// File: rtl/clkmul_schmitt_edge.sv
`default_nettype none
// ============================================================================
// Module   : schmitt_edge
// Brief    : Tick-qualified hysteresis comparator with a rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module schmitt_edge
  import clk_pkg::*;
#(
  parameter int                  W  = CLK_W,
  parameter logic signed [W-1:0] HI = SCHMITT_HI,
  parameter logic signed [W-1:0] LO = SCHMITT_LO
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic signed [W-1:0] i_sample,
  output logic                o_state,
  output logic                o_rise
);

  logic r_state;
  logic w_above;
  logic w_below;

  assign w_above = (i_sample > HI);
  assign w_below = (i_sample < LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= 1'b0;
    end else if (i_tick) begin
      if (w_above) begin
        r_state <= 1'b1;
      end else if (w_below) begin
        r_state <= 1'b0;
      end
    end
  end

  // Combinational so the owner sees the edge on the same tick it happens.
  assign o_state = r_state;
  assign o_rise  = i_tick & ~r_state & w_above;

endmodule
`default_nettype wire

// File: rtl/clkmul.sv
`default_nettype none
// ============================================================================
// Module   : clkmul
// Brief    : Tempo-locking clock multiplier; regenerates x1/x2/x4 of the clock
//            on sample_in0. Define CLKMUL_X8_EN to make sample_out3 an x8 clock.
// Revision : 1.0 - initial release
// ============================================================================
module clkmul
  import clk_pkg::*;
#(
  parameter int W          = CLK_W,
  parameter int FP_OFFSET  = CLK_FP_OFFSET,
  parameter int PERIOD_W   = CLK_PERIOD_W,
  parameter int MIN_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  clkmul_if.slave    bus
);

`ifdef CLKMUL_X8_EN
  localparam int c_nph = 4;
`else
  localparam int c_nph = 3;
`endif

  localparam logic signed [W-1:0]  c_thr_hi = W'(FROM_MV(2000, FP_OFFSET));
  localparam logic signed [W-1:0]  c_thr_lo = W'(FROM_MV(500, FP_OFFSET));
  localparam logic signed [W-1:0]  c_out_hi = W'(FROM_MV(5000, FP_OFFSET));
  localparam logic signed [W-1:0]  c_out_lo = '0;
  localparam logic [PERIOD_W-1:0] c_sat    = '1;
  localparam logic [PERIOD_W-1:0] c_min    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] c_two    = PERIOD_W'(2);

  logic [2:0]          r_sclk;
  logic                w_tick;
  logic                w_rise;
  logic                w_schmitt_state;
  logic [PERIOD_W-1:0] r_cnt, r_period;
  logic [PERIOD_W-1:0] w_cnt_inc, w_cnt_nxt, w_period_nxt;
  logic                r_locked, w_locked_nxt;
  logic                w_cnt_sat, w_valid;
  logic [c_nph-1:0]    w_level;
  logic signed [W-1:0] r_out0, r_out1, r_out2, r_out3;
  logic                w_unused;

  assign w_unused = ^{bus.sample_in1, bus.sample_in2, bus.sample_in3, w_schmitt_state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sclk <= '0;
    else        r_sclk <= {r_sclk[1:0], bus.sample_clk};
  end

  assign w_tick = r_sclk[1] & ~r_sclk[2];

  schmitt_edge #(.W(W), .HI(c_thr_hi), .LO(c_thr_lo)) u_schmitt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tick   (w_tick),
    .i_sample (bus.sample_in0),
    .o_state  (w_schmitt_state),
    .o_rise   (w_rise)
  );

  // w_cnt_inc counts the current sample, so edges 64 samples apart measure 64.
  // An edge arriving from saturation only re-arms the measurement.
  always_comb begin
    w_cnt_sat    = (r_cnt == c_sat);
    w_cnt_inc    = w_cnt_sat ? r_cnt : r_cnt + 1'b1;
    w_valid      = w_rise && (w_cnt_inc >= c_min);
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_locked_nxt = r_locked;
    if (w_valid) begin
      w_cnt_nxt    = '0;
      w_period_nxt = w_cnt_inc;
      w_locked_nxt = (w_cnt_inc != c_sat);
    end else if (w_tick) begin
      w_cnt_nxt = w_cnt_inc;
      if (w_cnt_inc == c_sat) w_locked_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= c_sat;
      r_period <= '0;
      r_locked <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  for (genvar g = 0; g < c_nph; g++) begin : g_phase
    logic [PERIOD_W-1:0] r_phase, w_phase_nxt, w_div, w_div_nxt;
    logic                w_enable;

    assign w_div     = r_period >> g;
    assign w_div_nxt = w_period_nxt >> g;
    // x2/x4 are judged on P4 and x8 on P8; too-short dividers hold the output LO.
    assign w_enable  = (g == 0) || ((w_period_nxt >> ((g == 3) ? 3 : 2)) >= c_two);

    always_comb begin
      w_phase_nxt = r_phase;
      if (w_valid) begin
        w_phase_nxt = '0;
      end else if (w_tick) begin
        if ((w_div == '0) || (r_phase >= w_div - 1'b1)) w_phase_nxt = '0;
        else                                           w_phase_nxt = r_phase + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_phase <= '0;
      else        r_phase <= w_phase_nxt;
    end

    assign w_level[g] = w_enable && (w_phase_nxt < (w_div_nxt >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out0 <= c_out_lo;
      r_out1 <= c_out_lo;
      r_out2 <= c_out_lo;
      r_out3 <= c_out_lo;
    end else begin
      r_out0 <= (w_locked_nxt && w_level[0]) ? c_out_hi : c_out_lo;
      r_out1 <= (w_locked_nxt && w_level[1]) ? c_out_hi : c_out_lo;
      r_out2 <= (w_locked_nxt && w_level[2]) ? c_out_hi : c_out_lo;
`ifdef CLKMUL_X8_EN
      r_out3 <= (w_locked_nxt && w_level[3]) ? c_out_hi : c_out_lo;
`else
      r_out3 <= w_locked_nxt ? c_out_hi : c_out_lo;
`endif
    end
  end

  assign bus.sample_out0 = r_out0;
  assign bus.sample_out1 = r_out1;
  assign bus.sample_out2 = r_out2;
  assign bus.sample_out3 = r_out3;

endmodule
`default_nettype wire
